// File: rtl/ifetch.sv
// Instruction-fetch stage: owns the PC, drives the synchronous IM, presents one instruction/cycle.
// Optional perf counters enabled by defining FETCH_PERF_EN.
module ifetch #(
    parameter int unsigned           PC_W      = 16,
    parameter int unsigned           INSTR_W   = 17,
    parameter logic [PC_W-1:0]       RESET_PC  = '0,
    parameter logic [INSTR_W-1:0]    NOP_INSTR = '0
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               stall_IM_ID,
    input  logic               flow_change_ID_EX,
    input  logic [PC_W-1:0]    dst_ID_EX,
    input  logic               hlt_ID_EX,
    output logic [PC_W-1:0]    im_addr,
    output logic               im_re,
    input  logic [INSTR_W-1:0] im_rdata,
    output logic [INSTR_W-1:0] instr,
    output logic [PC_W-1:0]    pc_IF,
    output logic [PC_W-1:0]    nxt_pc_IF,
    output logic               fetch_vld
`ifdef FETCH_PERF_EN
    ,
    output logic [15:0]        perf_fetch_cnt,
    output logic [15:0]        perf_stall_cnt
`endif
);

    typedef enum logic [1:0] {StBoot, StRun, StHold, StHalt} state_e;

    state_e             state_q, state_d;
    logic [PC_W-1:0]    pc_q, pc_d;
    logic [INSTR_W-1:0] hold_q, hold_d;
    logic [PC_W-1:0]    pc_inc;
    logic               active, take_redir, take_halt, take_stall, take_adv;

    assign pc_inc     = pc_q + 1'b1;
    assign active     = (state_q == StRun) || (state_q == StHold);
    // Priority: redirect > halt > stall > advance.
    assign take_redir = active && flow_change_ID_EX;
    assign take_halt  = active && !flow_change_ID_EX && hlt_ID_EX;
    assign take_stall = active && !flow_change_ID_EX && !hlt_ID_EX && stall_IM_ID;
    assign take_adv   = active && !flow_change_ID_EX && !hlt_ID_EX && !stall_IM_ID;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StBoot;
            pc_q    <= RESET_PC;
            hold_q  <= NOP_INSTR;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            hold_q  <= hold_d;
        end
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        hold_d  = hold_q;
        case (state_q)
            StBoot: state_d = StRun;
            StRun, StHold: begin
                if (take_redir) begin
                    pc_d    = dst_ID_EX;
                    state_d = StRun;
                end else if (take_halt) begin
                    state_d = StHalt;
                end else if (take_stall) begin
                    if (state_q == StRun) begin
                        hold_d  = im_rdata;
                        state_d = StHold;
                    end
                end else begin
                    pc_d    = pc_inc;
                    state_d = StRun;
                end
            end
            default: state_d = state_q;
        endcase
    end

    always_comb begin
        im_addr   = pc_q;
        im_re     = 1'b0;
        instr     = NOP_INSTR;
        fetch_vld = 1'b0;
        case (state_q)
            StBoot: begin
                im_addr = RESET_PC;
                im_re   = 1'b1;
            end
            StRun, StHold: begin
                fetch_vld = 1'b1;
                instr     = (state_q == StRun) ? im_rdata : hold_q;
                if (take_redir) begin
                    im_addr = dst_ID_EX;
                    im_re   = 1'b1;
                end else if (take_adv) begin
                    im_addr = pc_inc;
                    im_re   = 1'b1;
                end
            end
            default: ;
        endcase
    end

    assign pc_IF     = pc_q;
    assign nxt_pc_IF = pc_inc;

`ifdef FETCH_PERF_EN
    logic [15:0] fetch_cnt_q, stall_cnt_q;
    logic        stall_evt;

    assign stall_evt = (state_q == StHold) || ((state_q == StRun) && (state_d == StHold));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_cnt_q <= '0;
            stall_cnt_q <= '0;
        end else begin
            if (im_re && (state_q != StBoot) && (fetch_cnt_q != 16'hFFFF)) begin
                fetch_cnt_q <= fetch_cnt_q + 16'd1;
            end
            if (stall_evt && (stall_cnt_q != 16'hFFFF)) begin
                stall_cnt_q <= stall_cnt_q + 16'd1;
            end
        end
    end

    assign perf_fetch_cnt = fetch_cnt_q;
    assign perf_stall_cnt = stall_cnt_q;
`endif

endmodule
